// File: rtl/peak_muldiv_ctrl.sv
// peak_muldiv_ctrl: RV32 M-extension multiply/divide unit (restoring divide, shift-add multiply); optional macro PEAK_MULDIV_FAST_MUL_EN.
// Latency: DONE at accept+33 for iterated ops; accept+1 for divide-by-zero/overflow early-outs and, with the macro, multiplies.
// Backpressure: READY is low from accept until the op retires or is killed; START is only sampled while READY=1.
module peak_muldiv_ctrl #(
  parameter int DIV_EARLY_OUT = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        INST_MUL,
  input  logic        INST_MULH,
  input  logic        INST_MULHSU,
  input  logic        INST_MULHU,
  input  logic        INST_DIV,
  input  logic        INST_DIVU,
  input  logic        INST_REM,
  input  logic        INST_REMU,
  input  logic [31:0] RS1,
  input  logic [31:0] RS2,
  input  logic        KILL,
  output logic        READY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;       // dividend->quotient, or multiplier->product low half
  logic [31:0] b_q, b_d;       // divisor or multiplicand magnitude
  logic [31:0] r_q, r_d;       // partial remainder, or product high half
  logic        neg_q, neg_d;   // negate the magnitude result at the end
  logic [31:0] result_q, result_d;

  logic [2:0]  op_sel;
  logic        any_op, accept;
  logic        sgn_a, sgn_b, neg_a, neg_b;
  logic [31:0] mag_a, mag_b;
  logic        div0, ovf, early, neg_res, fast_sel;
  logic [32:0] r_sh, mul_sum;
  logic [31:0] r_sub;
  logic        div_ge;
  logic [63:0] prod, prod_s;
  logic [31:0] quo, rem, fin_val;

  assign any_op = INST_MUL | INST_MULH | INST_MULHSU | INST_MULHU |
                  INST_DIV | INST_DIVU | INST_REM    | INST_REMU;
  assign accept = (state_q == S_IDLE) & START & any_op & ~KILL;

  // Priority-decode the op flags and prepare operand magnitudes and result sign.
  always_comb begin
    op_sel = OP_REMU;
    if      (INST_MUL)    op_sel = OP_MUL;
    else if (INST_MULH)   op_sel = OP_MULH;
    else if (INST_MULHSU) op_sel = OP_MULHSU;
    else if (INST_MULHU)  op_sel = OP_MULHU;
    else if (INST_DIV)    op_sel = OP_DIV;
    else if (INST_DIVU)   op_sel = OP_DIVU;
    else if (INST_REM)    op_sel = OP_REM;
    sgn_a   = (op_sel == OP_MULH) | (op_sel == OP_MULHSU) | (op_sel == OP_DIV) | (op_sel == OP_REM);
    sgn_b   = (op_sel == OP_MULH) | (op_sel == OP_DIV) | (op_sel == OP_REM);
    neg_a   = sgn_a & RS1[31];
    neg_b   = sgn_b & RS2[31];
    mag_a   = neg_a ? (32'd0 - RS1) : RS1;
    mag_b   = neg_b ? (32'd0 - RS2) : RS2;
    div0    = op_sel[2] & (RS2 == 32'd0);
    ovf     = ((op_sel == OP_DIV) | (op_sel == OP_REM)) &
              (RS1 == 32'h8000_0000) & (RS2 == 32'hFFFF_FFFF);
    early   = (DIV_EARLY_OUT != 0) & (div0 | ovf);
    // A zero divisor yields an all-ones quotient regardless of operand signs;
    // the remainder always follows the dividend's sign.
    neg_res = (op_sel == OP_REM) ? neg_a : ((neg_a ^ neg_b) & ~div0);
  end

`ifdef PEAK_MULDIV_FAST_MUL_EN
  logic signed [63:0] fm_a, fm_b, fm_p;
  assign fm_a     = {{32{sgn_a & RS1[31]}}, RS1};
  assign fm_b     = {{32{sgn_b & RS2[31]}}, RS2};
  assign fm_p     = fm_a * fm_b;
  assign fast_sel = ~op_sel[2];
`else
  assign fast_sel = 1'b0;
`endif

  // One radix-2 step of restoring divide or shift-add multiply, plus final sign fix-up.
  always_comb begin
    r_sh    = {r_q, a_q[31]};
    div_ge  = (r_sh >= {1'b0, b_q});
    r_sub   = r_sh[31:0] - b_q;
    mul_sum = {1'b0, r_q} + (a_q[0] ? {1'b0, b_q} : 33'd0);
    prod    = {r_q, a_q};
    prod_s  = neg_q ? (64'd0 - prod) : prod;
    quo     = neg_q ? (32'd0 - a_q) : a_q;
    rem     = neg_q ? (32'd0 - r_q) : r_q;
    case (op_q)
      OP_MUL:                       fin_val = prod_s[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod_s[63:32];
      OP_DIV, OP_DIVU:              fin_val = quo;
      default:                      fin_val = rem;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: early-outs and fast multiplies skip CALC; KILL always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (early | fast_sel) ? S_FIN : S_CALC;
      S_CALC: begin
        if (KILL)               state_d = S_IDLE;
        else if (cnt_q == 6'd0) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: DONE only in an un-killed FIN; RESULT shows the fresh value while DONE is high.
  always_comb begin
    READY  = (state_q == S_IDLE);
    DONE   = (state_q == S_FIN) & ~KILL;
    RESULT = DONE ? fin_val : result_q;
  end

  // Datapath next values: capture on accept, iterate in CALC, latch result on retire.
  always_comb begin
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (accept) begin
      op_d  = op_sel;
      cnt_d = 6'd31;
      a_d   = mag_a;
      b_d   = mag_b;
      r_d   = 32'd0;
      neg_d = neg_res;
      if (early) begin
        // Preload the registers as if the iterations had already finished.
        a_d = div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
        r_d = div0 ? mag_a : 32'd0;
      end
`ifdef PEAK_MULDIV_FAST_MUL_EN
      else if (fast_sel) begin
        a_d   = fm_p[31:0];
        r_d   = fm_p[63:32];
        neg_d = 1'b0;
      end
`endif
    end else if ((state_q == S_CALC) && !KILL) begin
      cnt_d = (cnt_q == 6'd0) ? 6'd0 : cnt_q - 6'd1;
      if (op_q[2]) begin
        r_d = div_ge ? r_sub : r_sh[31:0];
        a_d = {a_q[30:0], div_ge};
      end else begin
        r_d = mul_sum[32:1];
        a_d = {mul_sum[0], a_q[31:1]};
      end
    end else if ((state_q == S_FIN) && !KILL) begin
      result_d = fin_val;
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q     <= OP_MUL;
      cnt_q    <= 6'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      r_q      <= 32'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
    end else begin
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule
